// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, valid/ready output
// with single-cycle framing-error and overrun pulses.
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | line idle, waiting for rx_s low
// START      | timing half a bit to the middle of the start bit
// DATA       | sampling NUMBER_OF_BITS data bits mid-bit, LSB first
// STOP       | waiting one bit to the middle of the stop bit
// WAIT_IDLE  | bad stop bit seen, waiting for the line to go high again
module uart_rx #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int BAUD_DIVIDER   = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [NUMBER_OF_BITS-1:0] data_bits,
    output logic                      framing_error,
    output logic                      overrun
);

    localparam int HALF   = BAUD_DIVIDER / 2;
    localparam int RATE_W = $clog2(BAUD_DIVIDER);
    localparam int IDX_W  = (NUMBER_OF_BITS > 1) ? $clog2(NUMBER_OF_BITS) : 1;

    localparam logic [RATE_W-1:0] RATE_HALF = RATE_W'(HALF - 1);
    localparam logic [RATE_W-1:0] RATE_FULL = RATE_W'(BAUD_DIVIDER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUMBER_OF_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                    state, state_next;
    logic [RATE_W-1:0]         rate_counter, rate_next;
    logic [IDX_W-1:0]          bit_index, index_next;
    logic [NUMBER_OF_BITS-1:0] shift_reg, shift_next;
    logic                      rx_meta, rx_s;
    logic                      deliver;
    logic                      frame_bad;

    // Reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            rate_counter <= '0;
            bit_index    <= '0;
            shift_reg    <= '0;
        end else begin
            state        <= state_next;
            rate_counter <= rate_next;
            bit_index    <= index_next;
            shift_reg    <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        rate_next  = rate_counter;
        index_next = bit_index;
        shift_next = shift_reg;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_next = S_START;
                    rate_next  = RATE_HALF;
                end
            end
            S_START: begin
                if (rate_counter != '0) begin
                    rate_next = rate_counter - RATE_W'(1);
                end else if (!rx_s) begin
                    state_next = S_DATA;
                    rate_next  = RATE_FULL;
                    index_next = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rate_counter != '0) begin
                    rate_next = rate_counter - RATE_W'(1);
                end else begin
                    shift_next = {rx_s, shift_reg[NUMBER_OF_BITS-1:1]};
                    rate_next  = RATE_FULL;
                    if (bit_index == IDX_LAST) begin
                        state_next = S_STOP;
                    end else begin
                        index_next = bit_index + IDX_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (rate_counter != '0) begin
                    rate_next = rate_counter - RATE_W'(1);
                end else if (rx_s) begin
                    deliver    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    frame_bad  = 1'b1;
                    state_next = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A new word may replace one being consumed on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_valid    <= 1'b0;
            data_bits     <= '0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= frame_bad;
            overrun       <= deliver && data_valid && !data_ready;
            if (deliver && (!data_valid || data_ready)) begin
                data_bits  <= shift_reg;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's uart_tx.
- Frame format: 8N1-style, meaning START(0), NUMBER_OF_BITS data bits LSB first, one STOP(1).
- Pin `rx` is asynchronous. It goes through a 2-flop synchroniser, then a bit-timing FSM that samples mid-bit.
- Each received word is presented on a valid/ready stream output.
- Framing errors and overruns are flagged with single-cycle pulses.

Parameters:
- NUMBER_OF_BITS, 8: data bits per frame.
- BAUD_DIVIDER, 4: clock cycles per bit. Legal values are >= 2. HALF = BAUD_DIVIDER/2 (integer division).

Ports:
- clock  input  1  system clock, all logic on its rising edge.
- reset_n  input  1  reset, asynchronous assert, active-low.
- rx  input  1  serial line, idle high, asynchronous to clock.
- data_valid  output  1  data_bits holds an unconsumed received word.
- data_ready  input  1  consumer accepts the word when data_valid && data_ready at a clock edge.
- data_bits  output  NUMBER_OF_BITS  received word.
- framing_error  output  1  1-cycle pulse: stop bit sampled 0.
- overrun  output  1  1-cycle pulse: a completed word was dropped because the output was still full.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - data_valid, framing_error and overrun = 0.
  - data_bits = 0.
  - Counters = 0.
  - Synchroniser flops = 1.
  - Reset mid-frame abandons the frame without flagging anything.
- Synchroniser: rx_s is rx delayed by 2 flops. The FSM uses only rx_s.
- Counters:
  - rate_counter is $clog2(BAUD_DIVIDER) bits wide. It counts down and reloads; it never wraps below 0.
  - bit_index runs 0..NUMBER_OF_BITS-1.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s==0, go to START and load rate_counter = HALF-1.
  - START: decrement while rate_counter != 0. At 0, sample rx_s:
    - rx_s==0: go to DATA, rate_counter = BAUD_DIVIDER-1, bit_index = 0.
    - rx_s==1: glitch/false start; return to IDLE with no flag.
  - DATA: decrement while rate_counter != 0. At 0:
    - Shift rx_s into the MSB of the shift register (right shift, so the first bit received ends at bit 0).
    - Reload rate_counter = BAUD_DIVIDER-1.
    - After the sample with bit_index == NUMBER_OF_BITS-1, go to STOP; otherwise increment bit_index.
  - STOP: at rate_counter == 0, sample rx_s:
    - rx_s==1: deliver the word (see Handshake); go to IDLE.
    - rx_s==0: framing_error = 1 for exactly one cycle; the word is discarded; go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents re-triggering on a held-low line or break.
- Timing:
  - E0 is the first rising edge at which rx is low at the start of a frame.
  - The IDLE→START transition happens at edge E0+2.
  - Data bit k is sampled at edge E0+2+HALF+(k+1)·BAUD_DIVIDER.
  - The stop bit is sampled at edge E0+2+HALF+(NUMBER_OF_BITS+1)·BAUD_DIVIDER.
  - data_valid is high from that edge on.
- Handshake:
  - data_valid, once set, stays high and data_bits stays stable until an edge with data_ready==1. At that edge data_valid clears.
  - On delivery, if data_valid==0, or data_valid && data_ready in the same cycle: load data_bits and set data_valid = 1. Back-to-back delivery takes priority over the clear.
  - On delivery while data_valid==1 && data_ready==0: keep the old word, drop the new one, and pulse overrun for 1 cycle.
- The FSM returns to IDLE at mid-stop-bit, so a START that immediately follows the stop bit is never missed.
- framing_error and overrun are mutually exclusive per frame. Neither blocks reception of later frames.

Test Plan:
- Loopback with uart_tx (NUMBER_OF_BITS=8, BAUD_DIVIDER=4), data_ready=1, send 0xA5 → data_valid rises 40 cycles after E0, with data_bits=0xA5 for exactly 1 cycle and no error pulses.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap and data_ready=1 → three words received in order, none lost, no flags.
- data_ready=0, send 0x11 then 0x22 → data_bits holds 0x11, overrun pulses once at the 2nd stop sample; after data_ready=1, data_valid clears and no 0x22 appears.
- Drive frame 0x55 with stop bit 0, then hold rx low 30 cycles, then high → one framing_error pulse, no data_valid; next valid frame 0x81 is received correctly.
- Glitch: rx low for 1 cycle at idle → START entered, false start detected, return to IDLE; no data_valid, no flags.
- Assert reset_n low mid-data-bit 3 of frame 0xC3, release, then send 0x7E → outputs 0 during reset; only 0x7E is delivered.
